// File: rtl/spi_frame_slave_if.sv
// Bus between the SPI frame slave, the host SPI pins and the processing core.
// spi_data_in moves on every clk edge where spi_data_in_valid && spi_data_in_ready; the core may hold valid as long as it likes.
interface spi_frame_slave_if #(
    parameter int TX_DEPTH = 8
);
    localparam int LW = $clog2(TX_DEPTH) + 1;

    logic          spi_sck;
    logic          spi_ss;
    logic          spi_mosi;
    logic          spi_miso;
    logic [7:0]    spi_cmd;
    logic          spi_cmd_valid;
    logic [7:0]    spi_data_out;
    logic          spi_data_out_valid;
    logic [7:0]    spi_data_in;
    logic          spi_data_in_valid;
    logic          spi_data_in_ready;
    logic [LW-1:0] tx_level;
    logic          frame_error;
    logic [1:0]    state_dbg;

    modport slave (
        input  spi_sck, spi_ss, spi_mosi, spi_data_in, spi_data_in_valid,
        output spi_miso, spi_cmd, spi_cmd_valid, spi_data_out, spi_data_out_valid,
               spi_data_in_ready, tx_level, frame_error, state_dbg
    );

    modport master (
        output spi_sck, spi_ss, spi_mosi, spi_data_in, spi_data_in_valid,
        input  spi_miso, spi_cmd, spi_cmd_valid, spi_data_out, spi_data_out_valid,
               spi_data_in_ready, tx_level, frame_error, state_dbg
    );
endinterface

// File: rtl/spi_frame_slave.sv
// Oversampled mode-0 SPI slave: opcode + payload frames, with a TX FIFO the host reads back through MISO.
// The frame FSM state appears on bus.state_dbg (0 IDLE, 1 FRAME, 2 DRAIN).
module spi_frame_slave #(
    parameter int FRAME_BYTES = 4,
    parameter int TX_DEPTH    = 8,
    parameter int LSB_FIRST   = 1
) (
    input logic              clk,
    input logic              reset,
    spi_frame_slave_if.slave bus
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0]    FB_CNT   = 8'(FRAME_BYTES);
    localparam logic [7:0]    LAST_IDX = 8'(FRAME_BYTES - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(TX_DEPTH);
    localparam logic [7:0]    OP_READ  = 8'h02;
    localparam logic [7:0]    OP_CMD   = 8'h03;
    localparam logic [7:0]    OP_DATA  = 8'h04;

    typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, DRAIN = 2'd2} state_t;

    // Synchronisers keep running through reset, so a frame already under way is seen as ss low with no falling edge.
    logic [1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic       sck_prev_q, ss_prev_q;
    logic       sck_s, ss_s, mosi_s, sck_rise, sck_fall;

    always_ff @(posedge clk) begin
        sck_sync_q  <= {sck_sync_q[0], bus.spi_sck};
        ss_sync_q   <= {ss_sync_q[0], bus.spi_ss};
        mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi};
        sck_prev_q  <= sck_sync_q[1];
        ss_prev_q   <= ss_sync_q[1];
    end

    assign sck_s    = sck_sync_q[1];
    assign ss_s     = ss_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign sck_rise = sck_s && !sck_prev_q;
    assign sck_fall = !sck_s && sck_prev_q;

    logic [7:0]    mem_q [TX_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop, pop_req, ready;
    logic [7:0]    fifo_rd;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] byte_cnt_q, rx_shift_q, tx_byte_q, opcode_q;
    logic       miso_q, cmd_valid_q, data_valid_q, frame_error_q;
    logic [7:0] cmd_q, data_q;

    logic [7:0] rx_shift_d, next_tx_d, status_d;
    logic [8:0] level_ext;
    logic       byte_done;

    function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] idx);
        return (LSB_FIRST != 0) ? b[idx] : b[3'd7 - idx];
    endfunction

    assign ready     = (level_q != FULL_LVL);
    assign fifo_rd   = mem_q[rd_ptr_q];
    assign level_ext = 9'(level_q);
    assign status_d  = {3'b010, (level_ext > 9'd15) ? 4'hF : level_ext[3:0], (level_q != '0)};

    always_comb begin
        rx_shift_d = (LSB_FIRST != 0) ? {mosi_s, rx_shift_q[7:1]} : {rx_shift_q[6:0], mosi_s};
        byte_done  = (state_q == FRAME) && !ss_s && sck_rise && (bit_cnt_q == 3'd7);
        // Completing byte k loads MISO for byte k+1, so the last payload byte triggers no pop.
        pop_req    = byte_done && (byte_cnt_q < LAST_IDX) &&
                     (((byte_cnt_q == 8'd0) ? rx_shift_d : opcode_q) == OP_READ);
        pop        = pop_req && (level_q != '0);
        next_tx_d  = pop ? fifo_rd : 8'h00;
        push       = bus.spi_data_in_valid && ready;
        level_d    = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.spi_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            rx_shift_q    <= '0;
            tx_byte_q     <= '0;
            opcode_q      <= '0;
            miso_q        <= 1'b0;
            cmd_q         <= '0;
            cmd_valid_q   <= 1'b0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            cmd_valid_q   <= 1'b0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (!ss_s) begin
                        if (ss_prev_q) begin
                            state_q    <= FRAME;
                            bit_cnt_q  <= '0;
                            byte_cnt_q <= '0;
                            tx_byte_q  <= status_d;
                            miso_q     <= pick_bit(status_d, 3'd0);
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                FRAME: begin
                    if (ss_s) begin
                        state_q <= IDLE;
                        miso_q  <= 1'b0;
                        if (bit_cnt_q != 3'd0 || byte_cnt_q != FB_CNT) begin
                            frame_error_q <= 1'b1;
                        end
                    end else begin
                        if (sck_rise) begin
                            rx_shift_q <= rx_shift_d;
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                        end
                        if (byte_done) begin
                            if (byte_cnt_q != FB_CNT) byte_cnt_q <= byte_cnt_q + 8'd1;
                            tx_byte_q <= next_tx_d;
                            if (byte_cnt_q == 8'd0) begin
                                opcode_q <= rx_shift_d;
                            end else if (byte_cnt_q <= LAST_IDX) begin
                                if (opcode_q == OP_CMD && byte_cnt_q == 8'd1) begin
                                    cmd_q       <= rx_shift_d;
                                    cmd_valid_q <= 1'b1;
                                end
                                if (opcode_q == OP_DATA) begin
                                    data_q       <= rx_shift_d;
                                    data_valid_q <= 1'b1;
                                end
                            end
                        end
                        if (sck_fall) miso_q <= pick_bit(tx_byte_q, bit_cnt_q);
                    end
                end
                default: begin
                    miso_q <= 1'b0;
                    if (ss_s) state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.spi_miso           = miso_q;
    assign bus.spi_cmd            = cmd_q;
    assign bus.spi_cmd_valid      = cmd_valid_q;
    assign bus.spi_data_out       = data_q;
    assign bus.spi_data_out_valid = data_valid_q;
    assign bus.spi_data_in_ready  = ready;
    assign bus.tx_level           = level_q;
    assign bus.frame_error        = frame_error_q;
    assign bus.state_dbg          = state_q;
endmodule

// File: doc/spi_frame_slave.md
Name: spi_frame_slave

Overview:
- Fabric-only SPI slave (no SB_SPI hard IP), successor to the fixed 4-byte command interface.
- Oversamples SCK/SS/MOSI on the system clock.
- Decodes frames of parametrised length: byte 0 = opcode, bytes 1..FRAME_BYTES-1 = payload.
- Returns processing-core data through a parametrised TX FIFO, replacing the single-byte input buffer. Sits between the host SPI link and the image-processing core.

Parameters:
- FRAME_BYTES, 4, bytes per frame including opcode; legal range 2..255.
- TX_DEPTH, 8, TX FIFO depth in bytes; power of 2, 2..256.
- LSB_FIRST, 1, 1 = bit 0 shifted first on MOSI/MISO; 0 = MSB first.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- spi_sck  in  1  SPI clock from host (mode 0), asynchronous
- spi_ss  in  1  chip select, active low, asynchronous
- spi_mosi  in  1  host-to-FPGA serial data
- spi_miso  out  1  FPGA-to-host serial data
- spi_cmd  out  8  last received command byte
- spi_cmd_valid  out  1  one-cycle pulse, spi_cmd updated
- spi_data_out  out  8  received payload byte
- spi_data_out_valid  out  1  one-cycle pulse per payload byte
- spi_data_in  in  8  byte from core for host readback
- spi_data_in_valid  in  1  core offers spi_data_in
- spi_data_in_ready  out  1  FIFO not full; push occurs when valid && ready
- tx_level  out  $clog2(TX_DEPTH)+1  current FIFO occupancy
- frame_error  out  1  one-cycle pulse on malformed frame

Behaviour:
- Reset values: spi_miso=0, spi_cmd=0, spi_data_out=0, all valids and frame_error=0, FIFO empty (tx_level=0, ready=1), byte and bit counters 0, state IDLE.
- Synchronisers: 2-flop on sck, ss and mosi. Edges are detected on the synchronised sck. Host SCK ≤ clk/8.
- State machine:
  - IDLE: wait for ss low, then enter FRAME.
  - FRAME: shift bits; transitions below.
  - DRAIN: after reset or an error, wait for ss high, then return to IDLE.
- Reset asserted while ss is low: after reset, enter DRAIN, not IDLE. The remainder of that frame is ignored.
- Mode 0 timing:
  - MOSI sampled on sck rising.
  - spi_miso updated on sck falling.
  - First MISO bit of a frame driven within 2 clk of ss falling.
  - spi_miso=0 whenever ss is high.
- Byte completes on the 8th rising edge; bit counter wraps to 0 and byte counter increments. Data is assembled per LSB_FIRST.
- Byte 0 MISO (status byte):
  - bit7=0, bit6=1, bit5=0
  - bits[4:1]=min(tx_level,15), sampled at ss fall
  - bit0 = FIFO non-empty
- Opcodes, decoded when byte 0 completes:
  - 0x00 NOP: payload ignored; MISO=0x00.
  - 0x02 READ_DATA: at completion of byte k (k=0..FRAME_BYTES-2), pop one FIFO byte into the MISO shifter for byte k+1. If the FIFO is empty, load 0x00 and pop nothing.
  - 0x03 RECEIVE_CMD: byte 1 → spi_cmd with spi_cmd_valid pulse, 2-3 clk after its 8th rising edge. Bytes 2.. ignored.
  - 0x04 RECEIVE_DATA: each byte 1..FRAME_BYTES-1 → spi_data_out with spi_data_out_valid pulse, same latency.
  - Any other opcode: ignored; MISO=0x00; no error.
- Bytes beyond FRAME_BYTES-1 in the same ss window: ignored, MISO=0x00, no pops, no pulses.
- ss rising: return to IDLE. If the bit counter ≠ 0 or fewer than FRAME_BYTES bytes were completed: pulse frame_error, discard the partial byte, then go to IDLE. Outputs already emitted stand.
- FIFO:
  - Push when spi_data_in_valid && spi_data_in_ready; ready = (tx_level != TX_DEPTH).
  - Push and pop in the same cycle: level unchanged. If the FIFO is empty, the pop sees empty (sends 0x00) and the push is retained.
  - Pointers wrap modulo TX_DEPTH.

Test Plan:
- Reset, then ss low, opcode 0x03, byte 0x5A, two 0x00, ss high → spi_cmd=0x5A with one spi_cmd_valid pulse; MISO byte 0 = 0x40; no frame_error.
- Opcode 0x04 with payload 0x11,0x22,0x33 → three spi_data_out_valid pulses carrying 0x11,0x22,0x33 in order.
- Push 0xA1,0xB2 into the FIFO, then READ_DATA frame → MISO bytes 0x45,0xA1,0xB2,0x00; tx_level returns to 0.
- Push TX_DEPTH+1 bytes with valid held high → ready drops at level 8 and the 9th byte is held. READ_DATA frame then pops 3; ready rises and the held byte is accepted.
- ss high after 13 bits of frame → frame_error pulse; no cmd/data pulse for the partial byte. Next frame decodes normally.
- Assert reset mid-frame with ss low, clock 10 more bits, ss high, then a new 0x03 frame → only the new frame produces spi_cmd_valid. Repeat all tests with LSB_FIRST=0 and FRAME_BYTES=6.
